// File: rtl/match_pkg.sv
// match_pkg: shared widths, point record and sweep FSM states for the matching front end
package match_pkg;
  localparam int ALPHA_W = 12;
  localparam int IDX_W = 5;
  localparam int COORD_W = 14;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [IDX_W-1:0] idx;
    logic last;
  } point_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
endpackage

// File: rtl/point_fifo.sv
// point_fifo: first-word-fall-through FIFO with occupancy count
// ports: wr_en/wr_data push; rd_en pops the head when valid; rd_data is the head (0 when empty); count is occupancy
module point_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          valid,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_rd;
  assign valid = count != '0;
  assign do_rd = rd_en && valid;
  assign rd_data = valid ? mem[rp] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      assert (!(wr_en && !do_rd && count == (AW+1)'(DEPTH)));
      if (wr_en) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, do_rd};
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= wr_data;
endmodule

// File: rtl/boundary_sweep_reader.sv
// boundary_sweep_reader: drives an alpha sweep into boundary_cal and streams captured points out
// ports: start/alpha_base launch a sweep; alpha feeds boundary_cal; xb_in/yb_in are its results;
//        out_* is the valid/ready point stream; busy is high outside IDLE; done pulses at sweep end
module boundary_sweep_reader
  import match_pkg::*;
#(
  parameter int M = 13,
  parameter int NPTS = 18,
  parameter int ALPHA_STEP = 200,
  parameter int CAL_LAT = 9,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ALPHA_W-1:0] alpha_base,
  output logic [ALPHA_W-1:0] alpha,
  input  logic [M:0]         xb_in,
  input  logic [M:0]         yb_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [M:0]         out_x,
  output logic [M:0]         out_y,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] NP = IDX_W'(NPTS);
  localparam logic [CW:0] DP = (CW+1)'(DEPTH);
  localparam logic [ALPHA_W-1:0] STEP = ALPHA_W'(ALPHA_STEP);
  state_t state, state_n;
  logic [ALPHA_W-1:0] nxt;
  logic [IDX_W-1:0] issue_cnt;
  logic [CAL_LAT:0] sr_v;
  logic [CAL_LAT:0][IDX_W-1:0] sr_idx;
  logic [CW-1:0] infl, fcnt;
  logic issue, cap;
  point_t wr_pt, rd_pt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // an alpha is issued only if its result already owns a FIFO slot, since boundary_cal cannot stall
  always_comb begin
    issue = state == SWEEP && issue_cnt < NP && ({1'b0, fcnt} + {1'b0, infl}) < DP;
    done = state == DRAIN && infl == '0;
    busy = state != IDLE;
    state_n = state == IDLE  ? (start ? SWEEP : IDLE) :
              state == SWEEP ? (issue_cnt == NP ? DRAIN : SWEEP) :
                               (infl == '0 ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alpha <= '0;
      nxt <= '0;
      issue_cnt <= '0;
      sr_v <= '0;
      infl <= '0;
    end else begin
      if (state == IDLE && start) begin
        nxt <= alpha_base;
        issue_cnt <= '0;
      end
      if (issue) begin
        alpha <= nxt;
        nxt <= nxt + STEP;
        issue_cnt <= issue_cnt + 1'b1;
      end
      sr_v <= {sr_v[CAL_LAT-1:0], issue};
      infl <= infl + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, cap};
    end
  always_ff @(posedge clk)
    sr_idx <= {sr_idx[CAL_LAT-1:0], issue_cnt};
  // stage 0 is loaded on the issue edge, so stage CAL_LAT lines up with boundary_cal's output
  assign cap = sr_v[CAL_LAT];
  assign wr_pt = '{x: xb_in, y: yb_in, idx: sr_idx[CAL_LAT], last: sr_idx[CAL_LAT] == NP - 1'b1};
  point_fifo #(.W($bits(point_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(cap),
    .wr_data(wr_pt),
    .rd_en(out_ready),
    .rd_data(rd_pt),
    .valid(out_valid),
    .count(fcnt)
  );
  assign out_x = rd_pt.x;
  assign out_y = rd_pt.y;
  assign out_idx = rd_pt.idx;
  assign out_last = rd_pt.last;
endmodule

// File: doc/boundary_sweep_reader.md
# boundary_sweep_reader

Sweep controller and result reader for `boundary_cal`, the pipelined ellipse-boundary generator. On `start` it drives a sequence of `NPTS` alpha angles into `boundary_cal` and captures each (xb, yb) point exactly `CAL_LAT` cycles after issue. Captured points go into a small FIFO and leave on a valid/ready stream toward the matching stage. `boundary_cal` has no stall, so the block issues an alpha only when a FIFO slot is guaranteed for its result.

## Interface
- `M`, 13: `boundary_cal` width parameter; point coordinates are M+1 bits.
- `NPTS`, 18: points per sweep, 1..31.
- `ALPHA_STEP`, 200: alpha increment per point, 12-bit.
- `CAL_LAT`, 9: `boundary_cal` latency, alpha-in to xb/yb-out, in clk cycles, ≥1.
- `DEPTH`, 8: output FIFO entries, power of two.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin sweep; accepted only in IDLE.
- `alpha_base` input 12: first alpha, sampled with accepted `start`.
- `alpha` output 12: angle driven to `boundary_cal`.
- `xb_in` input M+1: x coordinate from `boundary_cal`.
- `yb_in` input M+1: y coordinate from `boundary_cal`.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts head.
- `out_x` output M+1: point x.
- `out_y` output M+1: point y.
- `out_idx` output 5: point index 0..NPTS-1.
- `out_last` output 1: head is point NPTS-1.
- `busy` output 1: high outside IDLE.
- `done` output 1: one-cycle pulse when the last point is written into the FIFO.

## Operation
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE→SWEEP on `start`.
  - SWEEP→DRAIN in the cycle after issue count reaches NPTS.
  - DRAIN→IDLE when the in-flight shift register is empty. `done` pulses in that same cycle.
- Issue rule: issue in a SWEEP cycle iff `fifo_count + inflight_count + 0 < DEPTH`, using registered counts.
  - On issue, `alpha` holds the issued value and the in-flight shift register shifts in 1 with its index.
  - On a non-issue cycle, `alpha` holds its value and a 0 is shifted in.
- First issue uses `alpha_base`; each later issue uses previous + `ALPHA_STEP` mod 4096 (12-bit wrap, no saturation).
- Capture: when the shift-register tap at depth CAL_LAT is 1, write `{xb_in, yb_in, idx, idx==NPTS-1}` to the FIFO. `xb_in`/`yb_in` are used raw, no re-registering before the write.
- FIFO: standard first-word-fall-through behaviour.
  - Read and write in the same cycle are both honoured.
  - Credit rule guarantees no overflow. Overflow is an assertion failure, never a data path.
- `start` while busy is ignored. `alpha_base` is ignored outside the accepted `start`.
- The FIFO may still hold points after return to IDLE. A new `start` is accepted regardless; points stay in order.
- Reset mid-sweep:
  - state=IDLE; `alpha`=0; FIFO and shift register cleared.
  - `out_valid`=0, `out_x`=`out_y`=0, `out_idx`=0, `out_last`=0, `busy`=0, `done`=0.
  - Partial points are discarded.

## Timing
- `start` accepted at edge k: first issue drives `alpha`=`alpha_base` from edge k+1.
- That point's xb/yb is sampled at edge k+1+CAL_LAT and appears on `out_*` after edge k+2+CAL_LAT.
- With `out_ready` constantly high and DEPTH ≥ CAL_LAT+1, issue is back-to-back: one point per cycle, sweep completes in NPTS+CAL_LAT+1 cycles.
- With `out_ready` low, at most DEPTH points are issued or stored, then issue stalls. Issue resumes the cycle after a pop frees credit.
- `out_x`/`out_y`/`out_idx`/`out_last` stay stable while `out_valid` && !`out_ready`.

## Structure
- Shared package `match_pkg`:
  - `ALPHA_W`=12, `IDX_W`=5.
  - Point record typedef {x, y, idx, last}.
  - FSM state enum.
- Sub-module `point_fifo`: parameterized width/DEPTH, FWFT, count output. Instantiated once.
- The CAL_LAT shift register (valid + idx) and the FSM live in the top module.

## Test plan
- `alpha_base`=0, `out_ready`=1, `boundary_cal` modelled with CAL_LAT=9 → 18 points, alpha 0,200,…,3400, idx 0..17, `out_last` only on idx 17, `done` one pulse, `busy` low afterwards.
- `alpha_base`=3900 → second alpha 4100 mod 4096 = 4, third 204; model's xb/yb match those alphas.
- `out_ready` low for 40 cycles mid-sweep → in-flight + stored never exceeds 8, no lost or duplicated idx, stream resumes in order.
- Random `out_ready` (50%) over 20 sweeps → per-sweep idx sequence strictly 0..17, data equals model output.
- `rst` pulsed at sweep point 7 → all outputs 0 immediately (async). Next `start` gives a clean sweep from idx 0.
- `start` held high through a whole sweep → exactly one sweep per IDLE entry, back-to-back sweeps with no gap beyond one IDLE cycle.
